// File: rtl/alu_issue_scheduler.sv
`default_nettype none
// ============================================================================
// alu_issue_scheduler: ALU reservation station with CDB wakeup and one issue/cycle.
// Optional macro RS_AGE_ORDER_EN selects oldest-ready instead of lowest-index.
// Revision: 1.0
// ============================================================================
module alu_issue_scheduler #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 6
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic [5:0]       disp_opcode,
  input  logic [31:0]      disp_val1,
  input  logic [31:0]      disp_val2,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_pc,
  input  logic [TAG_W-1:0] disp_q1,
  input  logic [TAG_W-1:0] disp_q2,
  input  logic             disp_busy1,
  input  logic             disp_busy2,
  input  logic [TAG_W-1:0] disp_rob,
  input  logic             cdb_alu_valid,
  input  logic             cdb_lsb_valid,
  input  logic [TAG_W-1:0] cdb_alu_rob,
  input  logic [TAG_W-1:0] cdb_lsb_rob,
  input  logic [31:0]      cdb_alu_res,
  input  logic [31:0]      cdb_lsb_res,
  output logic             rs_full,
  output logic [5:0]       alu_opcode,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [TAG_W-1:0] alu_rob
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy_q, busy_d, w1_q, w1_d, w2_q, w2_d;
  logic [5:0]         op_q  [RS_SIZE];
  logic [5:0]         op_d  [RS_SIZE];
  logic [31:0]        v1_q  [RS_SIZE];
  logic [31:0]        v1_d  [RS_SIZE];
  logic [31:0]        v2_q  [RS_SIZE];
  logic [31:0]        v2_d  [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE];
  logic [31:0]        imm_d [RS_SIZE];
  logic [31:0]        pc_q  [RS_SIZE];
  logic [31:0]        pc_d  [RS_SIZE];
  logic [TAG_W-1:0]   q1_q  [RS_SIZE];
  logic [TAG_W-1:0]   q1_d  [RS_SIZE];
  logic [TAG_W-1:0]   q2_q  [RS_SIZE];
  logic [TAG_W-1:0]   q2_d  [RS_SIZE];
  logic [TAG_W-1:0]   rob_q [RS_SIZE];
  logic [TAG_W-1:0]   rob_d [RS_SIZE];

  logic [5:0]         aop_q, aop_d;
  logic [31:0]        av1_q, av1_d, av2_q, av2_d, aimm_q, aimm_d, apc_q, apc_d;
  logic [TAG_W-1:0]   arob_q, arob_d;

  logic [RS_SIZE-1:0] ready;
  logic               sel_found, free_found, dispatch_en;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  logic [32:0]        snoop1, snoop2, wk1, wk2;

`ifdef RS_AGE_ORDER_EN
  // Relative age (counter minus stamp) keeps the compare correct across counter wrap.
  localparam int AGE_W = IDX_W + 2;
  logic [AGE_W-1:0] age_q [RS_SIZE];
  logic [AGE_W-1:0] age_d [RS_SIZE];
  logic [AGE_W-1:0] cnt_q, cnt_d;
  logic [AGE_W-1:0] best_dist, dist;
`endif

  // Returns {still_waiting, value}; the ALU broadcast wins over the LSB one.
  function automatic logic [32:0] resolve(
    input logic             waiting,
    input logic [TAG_W-1:0] tag,
    input logic [31:0]      val,
    input logic             av,
    input logic [TAG_W-1:0] ar,
    input logic [31:0]      ares,
    input logic             lv,
    input logic [TAG_W-1:0] lr,
    input logic [31:0]      lres
  );
    if (!waiting)             resolve = {1'b0, val};
    else if (av && ar == tag) resolve = {1'b0, ares};
    else if (lv && lr == tag) resolve = {1'b0, lres};
    else                      resolve = {1'b1, val};
  endfunction

  assign rs_full     = &busy_q;
  assign ready       = busy_q & ~w1_q & ~w2_q;
  assign dispatch_en = rdy_in && !flush && (disp_opcode != 6'd0) && !rs_full;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_AGE_ORDER_EN
    best_dist = '0;
    dist      = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      dist = cnt_q - age_q[i];
      if (ready[i] && (!sel_found || dist > best_dist)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_dist = dist;
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
`endif
  end

  always_comb begin
    busy_d = busy_q;
    w1_d   = w1_q;
    w2_d   = w2_q;
    op_d   = op_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    q1_d   = q1_q;
    q2_d   = q2_q;
    rob_d  = rob_q;
    aop_d  = 6'd0;
    av1_d  = av1_q;
    av2_d  = av2_q;
    aimm_d = aimm_q;
    apc_d  = apc_q;
    arob_d = arob_q;
    wk1    = '0;
    wk2    = '0;
`ifdef RS_AGE_ORDER_EN
    age_d  = age_q;
    cnt_d  = cnt_q;
`endif
    snoop1 = resolve(disp_busy1, disp_q1, disp_val1, cdb_alu_valid, cdb_alu_rob,
                     cdb_alu_res, cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_res);
    snoop2 = resolve(disp_busy2, disp_q2, disp_val2, cdb_alu_valid, cdb_alu_rob,
                     cdb_alu_res, cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_res);

    if (flush) begin
      busy_d = '0;
      w1_d   = '0;
      w2_d   = '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          wk1 = resolve(w1_q[i], q1_q[i], v1_q[i], cdb_alu_valid, cdb_alu_rob,
                        cdb_alu_res, cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_res);
          wk2 = resolve(w2_q[i], q2_q[i], v2_q[i], cdb_alu_valid, cdb_alu_rob,
                        cdb_alu_res, cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_res);
          w1_d[i] = wk1[32];
          v1_d[i] = wk1[31:0];
          w2_d[i] = wk2[32];
          v2_d[i] = wk2[31:0];
        end
      end

      if (sel_found) begin
        busy_d[sel_idx] = 1'b0;
        aop_d  = op_q[sel_idx];
        av1_d  = v1_q[sel_idx];
        av2_d  = v2_q[sel_idx];
        aimm_d = imm_q[sel_idx];
        apc_d  = pc_q[sel_idx];
        arob_d = rob_q[sel_idx];
      end

      // free_idx comes from pre-edge state, so the slot just issued is never reused here.
      if (dispatch_en && free_found) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = disp_opcode;
        w1_d[free_idx]   = snoop1[32];
        v1_d[free_idx]   = snoop1[31:0];
        w2_d[free_idx]   = snoop2[32];
        v2_d[free_idx]   = snoop2[31:0];
        q1_d[free_idx]   = disp_q1;
        q2_d[free_idx]   = disp_q2;
        imm_d[free_idx]  = disp_imm;
        pc_d[free_idx]   = disp_pc;
        rob_d[free_idx]  = disp_rob;
`ifdef RS_AGE_ORDER_EN
        age_d[free_idx]  = cnt_q;
        cnt_d            = cnt_q + AGE_W'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q <= '0;
      w1_q   <= '0;
      w2_q   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        rob_q[i] <= '0;
`ifdef RS_AGE_ORDER_EN
        age_q[i] <= '0;
`endif
      end
`ifdef RS_AGE_ORDER_EN
      cnt_q  <= '0;
`endif
      aop_q  <= '0;
      av1_q  <= '0;
      av2_q  <= '0;
      aimm_q <= '0;
      apc_q  <= '0;
      arob_q <= '0;
    end else begin
      busy_q <= busy_d;
      w1_q   <= w1_d;
      w2_q   <= w2_d;
      op_q   <= op_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
      q1_q   <= q1_d;
      q2_q   <= q2_d;
      rob_q  <= rob_d;
`ifdef RS_AGE_ORDER_EN
      age_q  <= age_d;
      cnt_q  <= cnt_d;
`endif
      aop_q  <= aop_d;
      av1_q  <= av1_d;
      av2_q  <= av2_d;
      aimm_q <= aimm_d;
      apc_q  <= apc_d;
      arob_q <= arob_d;
    end
  end

  assign alu_opcode = aop_q;
  assign alu_val1   = av1_q;
  assign alu_val2   = av2_q;
  assign alu_imm    = aimm_q;
  assign alu_pc     = apc_q;
  assign alu_rob    = arob_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_scheduler.sv
`default_nettype none
// Testbench for alu_issue_scheduler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_alu_issue_scheduler;
  localparam int RS    = 8;
  localparam int TAG_W = 6;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b1;
  logic             rdy_in, flush;
  logic [5:0]       disp_opcode;
  logic [31:0]      disp_val1, disp_val2, disp_imm, disp_pc;
  logic [TAG_W-1:0] disp_q1, disp_q2, disp_rob;
  logic             disp_busy1, disp_busy2;
  logic             cdb_alu_valid, cdb_lsb_valid;
  logic [TAG_W-1:0] cdb_alu_rob, cdb_lsb_rob;
  logic [31:0]      cdb_alu_res, cdb_lsb_res;
  logic             rs_full;
  logic [5:0]       alu_opcode;
  logic [31:0]      alu_val1, alu_val2, alu_imm, alu_pc;
  logic [TAG_W-1:0] alu_rob;

  alu_issue_scheduler #(.RS_SIZE(RS), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
    .disp_opcode(disp_opcode), .disp_val1(disp_val1), .disp_val2(disp_val2),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_q1(disp_q1), .disp_q2(disp_q2),
    .disp_busy1(disp_busy1), .disp_busy2(disp_busy2), .disp_rob(disp_rob),
    .cdb_alu_valid(cdb_alu_valid), .cdb_lsb_valid(cdb_lsb_valid),
    .cdb_alu_rob(cdb_alu_rob), .cdb_lsb_rob(cdb_lsb_rob),
    .cdb_alu_res(cdb_alu_res), .cdb_lsb_res(cdb_lsb_res),
    .rs_full(rs_full), .alu_opcode(alu_opcode), .alu_val1(alu_val1),
    .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob(alu_rob)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit               busy;
    logic [5:0]       op;
    logic [31:0]      v1, v2, imm, pc;
    logic [TAG_W-1:0] q1, q2, rob;
    bit               w1, w2;
    int unsigned      seq;
  } ent_t;

  ent_t        m [RS];
  int unsigned m_seq;
  logic [5:0]  e_op;
  logic [31:0] e_v1, e_v2, e_imm, e_pc;
  logic [TAG_W-1:0] e_rob;
  bit          m_full;
  int          m_sel, m_fr;
  logic [31:0] tmp;

  function automatic bit cdb_hit(input logic [TAG_W-1:0] t, output logic [31:0] v);
    v = 32'h0;
    if (cdb_alu_valid && cdb_alu_rob == t) begin v = cdb_alu_res; return 1'b1; end
    if (cdb_lsb_valid && cdb_lsb_rob == t) begin v = cdb_lsb_res; return 1'b1; end
    return 1'b0;
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS; i++) begin m[i].busy = 0; m[i].w1 = 0; m[i].w2 = 0; end
      e_op = 0; e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0; m_seq = 0;
    end else if (flush) begin
      for (int i = 0; i < RS; i++) m[i].busy = 0;
      e_op = 0;
    end else if (!rdy_in) begin
      e_op = 0;
    end else begin
      m_sel = -1;
      m_fr  = -1;
      for (int i = 0; i < RS; i++) begin
        if (m[i].busy && !m[i].w1 && !m[i].w2) begin
`ifdef RS_AGE_ORDER_EN
          if (m_sel < 0 || m[i].seq < m[m_sel].seq) m_sel = i;
`else
          if (m_sel < 0) m_sel = i;
`endif
        end
        if (!m[i].busy && m_fr < 0) m_fr = i;
      end
      for (int i = 0; i < RS; i++) begin
        if (m[i].busy && m[i].w1 && cdb_hit(m[i].q1, tmp)) begin m[i].v1 = tmp; m[i].w1 = 0; end
        if (m[i].busy && m[i].w2 && cdb_hit(m[i].q2, tmp)) begin m[i].v2 = tmp; m[i].w2 = 0; end
      end
      if (m_sel >= 0) begin
        e_op = m[m_sel].op; e_v1 = m[m_sel].v1; e_v2 = m[m_sel].v2;
        e_imm = m[m_sel].imm; e_pc = m[m_sel].pc; e_rob = m[m_sel].rob;
        m[m_sel].busy = 0;
      end else begin
        e_op = 0;
      end
      if (disp_opcode != 0 && m_fr >= 0) begin
        m[m_fr].busy = 1; m[m_fr].op = disp_opcode; m[m_fr].imm = disp_imm;
        m[m_fr].pc = disp_pc; m[m_fr].rob = disp_rob;
        m[m_fr].q1 = disp_q1; m[m_fr].q2 = disp_q2;
        m[m_fr].v1 = disp_val1; m[m_fr].v2 = disp_val2;
        m[m_fr].w1 = disp_busy1; m[m_fr].w2 = disp_busy2;
        if (disp_busy1 && cdb_hit(disp_q1, tmp)) begin m[m_fr].v1 = tmp; m[m_fr].w1 = 0; end
        if (disp_busy2 && cdb_hit(disp_q2, tmp)) begin m[m_fr].v2 = tmp; m[m_fr].w2 = 0; end
        m[m_fr].seq = m_seq;
        m_seq++;
      end
    end
    m_full = 1;
    for (int i = 0; i < RS; i++) if (!m[i].busy) m_full = 0;
  end

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      chk("rs_full", 32'(rs_full), 32'(m_full));
      chk("alu_opcode", 32'(alu_opcode), 32'(e_op));
      if (e_op != 0) begin
        chk("alu_val1", alu_val1, e_v1);
        chk("alu_val2", alu_val2, e_v2);
        chk("alu_imm", alu_imm, e_imm);
        chk("alu_pc", alu_pc, e_pc);
        chk("alu_rob", 32'(alu_rob), 32'(e_rob));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    rdy_in = 1; flush = 0; disp_opcode = 0;
    disp_val1 = 0; disp_val2 = 0; disp_imm = 0; disp_pc = 0;
    disp_q1 = 0; disp_q2 = 0; disp_busy1 = 0; disp_busy2 = 0; disp_rob = 0;
    cdb_alu_valid = 0; cdb_lsb_valid = 0; cdb_alu_rob = 0; cdb_lsb_rob = 0;
    cdb_alu_res = 0; cdb_lsb_res = 0;
  endtask

  task automatic step();
    @(negedge clk_in);
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 rst_n_in = 0;
    repeat (2) @(negedge clk_in);
    #2 rst_n_in = 1;
    @(negedge clk_in);
  endtask

  task automatic drive_disp(input logic [5:0] op, input logic [31:0] v1, input logic b1,
                            input logic [TAG_W-1:0] q1, input logic [31:0] v2, input logic b2,
                            input logic [TAG_W-1:0] q2, input logic [31:0] imm,
                            input logic [TAG_W-1:0] rob);
    disp_opcode = op; disp_val1 = v1; disp_busy1 = b1; disp_q1 = q1;
    disp_val2 = v2; disp_busy2 = b2; disp_q2 = q2; disp_imm = imm;
    disp_rob = rob; disp_pc = 32'h1000 + 32'(rob) * 4;
  endtask

  task automatic random_drive();
    disp_opcode = ($urandom_range(0, 9) < 6) ? 6'($urandom_range(1, 63)) : 6'd0;
    disp_val1 = $urandom; disp_val2 = $urandom; disp_imm = $urandom; disp_pc = $urandom;
    disp_busy1 = 1'($urandom_range(0, 1)); disp_busy2 = 1'($urandom_range(0, 1));
    disp_q1 = TAG_W'($urandom_range(0, 7)); disp_q2 = TAG_W'($urandom_range(0, 7));
    disp_rob = TAG_W'($urandom_range(0, 63));
    cdb_alu_valid = ($urandom_range(0, 2) != 0); cdb_lsb_valid = ($urandom_range(0, 2) != 0);
    cdb_alu_rob = TAG_W'($urandom_range(0, 7)); cdb_lsb_rob = TAG_W'($urandom_range(0, 7));
    cdb_alu_res = $urandom; cdb_lsb_res = $urandom;
    flush = ($urandom_range(0, 63) == 0);
    rdy_in = ($urandom_range(0, 9) != 0);
  endtask

  initial begin
    idle_inputs();
    #1 rst_n_in = 0;
    #3;
    chk("reset_opcode", 32'(alu_opcode), 0);
    chk("reset_val1", alu_val1, 0);
    chk("reset_rob", 32'(alu_rob), 0);
    chk("reset_full", 32'(rs_full), 0);
    repeat (2) @(negedge clk_in);
    #2 rst_n_in = 1;
    @(negedge clk_in);

    // ADDI with both operands ready: visible two edges after being driven
    drive_disp(6'd19, 32'd5, 0, 0, 32'd0, 0, 0, 32'd3, 6'd2);
    step(); chk("addi_early", 32'(alu_opcode), 0);
    step(); chk("addi_op", 32'(alu_opcode), 19); chk("addi_v1", alu_val1, 5);
    chk("addi_imm", alu_imm, 3); chk("addi_rob", 32'(alu_rob), 2);
    step(); chk("addi_idle", 32'(alu_opcode), 0);

    // ADD waiting on tag 7, woken by LSB broadcast two cycles later
    drive_disp(6'd2, 32'd0, 1, 6'd7, 32'h22, 0, 0, 32'd0, 6'd5);
    step(); chk("add_wait1", 32'(alu_opcode), 0);
    step(); chk("add_wait2", 32'(alu_opcode), 0);
    cdb_lsb_valid = 1; cdb_lsb_rob = 6'd7; cdb_lsb_res = 32'h10;
    step(); chk("add_no_early", 32'(alu_opcode), 0);
    step(); chk("add_op", 32'(alu_opcode), 2); chk("add_v1", alu_val1, 32'h10);
    chk("add_v2", alu_val2, 32'h22); chk("add_rob", 32'(alu_rob), 5);

    // fill, dropped ninth dispatch, single wakeup frees one slot
    do_reset();
    for (int i = 0; i < RS; i++) begin
      drive_disp(6'd3, 32'(i), 1, TAG_W'(8 + i), 32'h5, 0, 0, 32'(i), TAG_W'(i));
      step();
    end
    chk("fill_full", 32'(rs_full), 1);
    drive_disp(6'd4, 32'd1, 0, 0, 32'd1, 0, 0, 32'd0, 6'd20);
    step(); chk("drop_full", 32'(rs_full), 1); chk("drop_idle", 32'(alu_opcode), 0);
    cdb_alu_valid = 1; cdb_alu_rob = 6'd8; cdb_alu_res = 32'h77;
    step(); chk("wake_still_full", 32'(rs_full), 1);
    step(); chk("wake_op", 32'(alu_opcode), 3); chk("wake_rob", 32'(alu_rob), 0);
    chk("wake_v1", alu_val1, 32'h77); chk("wake_not_full", 32'(rs_full), 0);
    for (int t = 9; t < 16; t++) begin
      cdb_alu_valid = 1; cdb_alu_rob = TAG_W'(t); cdb_alu_res = 32'(t);
      step();
    end
    repeat (3) step();

    // entry 3 (older) and entry 1 (newer) ready together
    do_reset();
    drive_disp(6'd5, 0, 1, 6'd20, 0, 0, 0, 0, 6'd0); step();
    drive_disp(6'd5, 0, 1, 6'd21, 0, 0, 0, 0, 6'd1); step();
    drive_disp(6'd5, 0, 1, 6'd20, 0, 0, 0, 0, 6'd2); step();
    drive_disp(6'd5, 0, 1, 6'd23, 0, 0, 0, 0, 6'd3); step();
    cdb_alu_valid = 1; cdb_alu_rob = 6'd21; step();
    step(); chk("age_free_rob", 32'(alu_rob), 1);
    drive_disp(6'd6, 0, 1, 6'd23, 0, 0, 0, 0, 6'd11); step();
    cdb_lsb_valid = 1; cdb_lsb_rob = 6'd23; cdb_lsb_res = 32'h99; step();
    chk("age_none_yet", 32'(alu_opcode), 0);
    step();
`ifdef RS_AGE_ORDER_EN
    chk("age_first", 32'(alu_rob), 3);
    step(); chk("age_second", 32'(alu_rob), 11);
`else
    chk("index_first", 32'(alu_rob), 11);
    step(); chk("index_second", 32'(alu_rob), 3);
`endif
    cdb_alu_valid = 1; cdb_alu_rob = 6'd20; step();
    repeat (3) step();

    // flush overrides a pending issue and a concurrent dispatch
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_disp(6'd7, 32'(i), 1, TAG_W'(40 + i), 0, 0, 0, 0, TAG_W'(i)); step();
    end
    cdb_alu_valid = 1; cdb_alu_rob = 6'd40; step();
    drive_disp(6'd8, 32'd1, 0, 0, 32'd2, 0, 0, 0, 6'd30); flush = 1;
    step(); chk("flush_op", 32'(alu_opcode), 0); chk("flush_full", 32'(rs_full), 0);
    step(); chk("flush_empty", 32'(alu_opcode), 0);

    // asynchronous reset while an issue is on the output
    drive_disp(6'd9, 32'hAA, 0, 0, 0, 0, 0, 0, 6'd12); step();
    step(); chk("pre_rst_op", 32'(alu_opcode), 9);
    #2 rst_n_in = 0;
    #1 chk("async_rst_op", 32'(alu_opcode), 0); chk("async_rst_v1", alu_val1, 0);
    chk("async_rst_full", 32'(rs_full), 0);
    @(negedge clk_in);
    #2 rst_n_in = 1;
    @(negedge clk_in);

    for (int c = 0; c < 3000; c++) begin
      random_drive();
      @(negedge clk_in);
    end
    idle_inputs();
    repeat (5) @(negedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_scheduler.md
ALU_ISSUE_SCHEDULER -- requirements
Module: alu_issue_scheduler

Interface
REQ-001 The block SHALL expose parameter RS_SIZE, default 8, meaning number of reservation entries (power of two, 2..16).
REQ-002 The block SHALL expose parameter TAG_W, default 6, meaning ROB index width.
REQ-003 clk_in  input  1  clock; all state changes on rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  global enable; low freezes all entry state.
REQ-006 flush  input  1  misprediction flush from CDB.
REQ-007 disp_opcode  input  6  dispatched opcode; 0 means no dispatch this cycle.
REQ-008 disp_val1, disp_val2, disp_imm, disp_pc  input  32 each  operand values, immediate, PC.
REQ-009 disp_q1, disp_q2  input  TAG_W each  producer ROB tags for val1/val2.
REQ-010 disp_busy1, disp_busy2  input  1 each  operand waits on tag when high.
REQ-011 disp_rob  input  TAG_W  destination ROB index.
REQ-012 cdb_alu_valid, cdb_lsb_valid  input  1 each  result broadcasts.
REQ-013 cdb_alu_rob, cdb_lsb_rob  input  TAG_W each; cdb_alu_res, cdb_lsb_res  input  32 each.
REQ-014 rs_full  output  1  all entries occupied (combinational from registers).
REQ-015 alu_opcode  output  6  registered issue opcode; 0 means idle.
REQ-016 alu_val1, alu_val2, alu_imm, alu_pc  output  32 each; alu_rob  output  TAG_W; all registered.

Function
REQ-017 An entry SHALL hold busy flag, opcode, val1/val2, q1/q2, wait1/wait2, imm, pc, rob.
REQ-018 Dispatch with disp_opcode != 0 and rs_full low SHALL write the lowest-index free entry at the edge; with rs_full high dispatch SHALL be ignored.
REQ-019 Each cycle, for each busy waiting operand whose tag equals a valid CDB tag, the block SHALL capture that CDB value and clear wait at the edge; ALU port takes priority if both CDB ports match.
REQ-020 A dispatch SHALL snoop same-cycle CDB: a matching busy operand is stored already resolved with the CDB value.
REQ-021 An entry is ready when busy and both wait flags low; a ready entry SHALL be selected per REQ-031 and its fields latched onto alu_* at the edge, freeing the entry the same edge.
REQ-022 With no ready entry, alu_opcode SHALL be 0 after the edge; other alu_* outputs are don't-care.
REQ-023 Latency: dispatch with both operands ready at cycle N SHALL appear on alu_opcode in cycle N+2 (write at end of N, issue latch at end of N+1); CDB wakeup in cycle N SHALL permit issue latch at end of N+1.
REQ-024 At most one entry SHALL issue per cycle; dispatch and issue in the same cycle SHALL both take effect, and a freed slot SHALL not be reusable until the next cycle (rs_full uses pre-edge state).
REQ-025 flush high SHALL clear all busy flags and force alu_opcode to 0 at the edge, overriding dispatch, wakeup and issue.
REQ-026 rdy_in low (flush low) SHALL hold all entries unchanged and force alu_opcode to 0 at the edge.
REQ-027 Operand values SHALL be stored unmodified at 32 bits; no arithmetic is performed.

Reset
REQ-028 rst_n_in low SHALL immediately clear all busy and wait flags, set alu_opcode to 0 and all other alu_* outputs to 0, independent of clk_in.
REQ-029 Reset deassertion SHALL be used directly; first dispatch may occur on the first edge after release.
REQ-030 rs_full SHALL read 0 while and after reset.

Configuration
REQ-031 Macro RS_AGE_ORDER_EN defined: each entry SHALL carry an age stamp set from a wrapping dispatch counter, and selection SHALL pick the oldest ready entry (wrap-safe via relative age); undefined: selection SHALL pick the lowest-index ready entry and no age logic exists.

Verification
REQ-032 Reset then dispatch ADDI val1=5 imm=3 rob=2 both ready at cycle 1 -> alu_opcode=ADDI, alu_val1=5, alu_imm=3, alu_rob=2 in cycle 3, idle cycle 4.
REQ-033 Dispatch ADD wait1 on tag 7, then cdb_lsb_valid rob=7 res=0x10 two cycles later -> issue with alu_val1=0x10 next cycle; no issue before.
REQ-034 Fill 8 entries all waiting -> rs_full=1; 9th dispatch dropped; one wakeup+issue -> rs_full=0 cycle after issue edge.
REQ-035 Entries 3 (older) and 1 (newer) become ready same cycle -> RS_AGE_ORDER_EN: entry 3 issues first; undefined: entry 1 first.
REQ-036 flush with 4 busy entries plus concurrent dispatch -> all entries empty, alu_opcode=0, rs_full=0 next cycle; rst_n_in pulsed mid-issue -> alu_opcode=0 asynchronously.
